pac_man_mover: RTL and testbench
================================

PAC_MAN_MOVER -- requirements
Module: pac_man_mover

Interface
REQ-001 Parameter GRID_W, default 32, maze columns in blocks.
REQ-002 Parameter GRID_H, default 24, maze rows in blocks; NUM_BLOCKS = GRID_W*GRID_H = 768.
REQ-003 Parameter START_BLOCK, default 495, spawn block index (row*GRID_W + col).
REQ-004 Parameter PELLET_POINTS, default 10, score added per pellet.
REQ-005 clk  in  1  sole clock; all state updates on rising edge.
REQ-006 reset  in  1  synchronous, active-high.
REQ-007 move_tick  in  1  single-cycle movement strobe.
REQ-008 next_block  in  10  requested block from the direction stage.
REQ-009 wall_rd_addr  out  10  maze wall ROM address.
REQ-010 wall_rd_data  in  1  wall bit (1 = wall); valid one cycle after address.
REQ-011 curr_block  out  10  committed Pac-Man block; fed back to the direction stage.
REQ-012 ready  out  1  high only in IDLE.
REQ-013 moved  out  1  one-cycle pulse on commit of a move.
REQ-014 blocked  out  1  one-cycle pulse on a rejected move.
REQ-015 pellet_eaten  out  1  one-cycle pulse when a pellet is consumed.
REQ-016 score  out  16  accumulated score.
REQ-017 level_clear  out  1  sticky; high once all pellets are eaten.

Function
REQ-018 FSM states: INIT, IDLE, CHECK, EAT, DONE; all outputs registered.
REQ-019 INIT: sweep counter c = 0..767 drives wall_rd_addr; one cycle later pellet[c] written as ~wall_rd_data AND c != START_BLOCK; remaining counter incremented per pellet written; after the last write (769 cycles) go IDLE.
REQ-020 IDLE, move_tick=1, next_block != curr_block, next_block < NUM_BLOCKS: latch target = next_block, wall_rd_addr = next_block, go CHECK.
REQ-021 IDLE, move_tick=1, next_block >= NUM_BLOCKS: blocked pulses next cycle, stay IDLE.
REQ-022 IDLE, move_tick=1, next_block == curr_block: no action, no pulse.
REQ-023 move_tick outside IDLE is dropped, not queued; next_block changes after latch are ignored.
REQ-024 CHECK, wall_rd_data=1: blocked pulse, curr_block unchanged, go IDLE.
REQ-025 CHECK, wall_rd_data=0: curr_block <= target, moved pulse, issue pellet read of target, go EAT.
REQ-026 EAT, pellet bit=1: clear bit, score += PELLET_POINTS saturating at 16'hFFFF, remaining -= 1, pellet_eaten pulse; if remaining reaches 0, level_clear <= 1, go DONE; else go IDLE.
REQ-027 EAT, pellet bit=0: no score change, go IDLE.
REQ-028 Move latency: tick in cycle T -> moved in T+2 -> pellet_eaten/score in T+3; minimum tick spacing for acceptance 3 cycles.
REQ-029 DONE: ignore move_tick; hold all outputs until reset.
REQ-030 INIT with zero open blocks: level_clear set at INIT end, go DONE.

Reset
REQ-031 reset in any state, including mid-move: state INIT, c = 0, curr_block = START_BLOCK, score = 0, remaining = 0, level_clear = 0, ready/moved/blocked/pellet_eaten = 0, wall_rd_addr = 0.
REQ-032 Pellet map fully rewritten by INIT after every reset; no stale pellet survives.

Structure
REQ-033 Package pac_man_pkg holds GRID_W, GRID_H, NUM_BLOCKS, START_BLOCK default, PELLET_POINTS, block_t (logic [9:0]), mover state enum.
REQ-034 Sub-module pellet_map: NUM_BLOCKS x 1 RAM, one sync-read port (1-cycle latency), one write port; write-before-read at same address not required.

Verification
REQ-035 Reset, release, all-open wall model: ready rises exactly 769 cycles later; curr_block 495, score 0, level_clear 0.
REQ-036 Tick with next_block 496, wall 0: moved at T+2, curr_block 496; pellet_eaten at T+3, score 10; return to 495: moved, no pellet_eaten, score 10.
REQ-037 Wall at 463, tick with next_block 463: blocked at T+2, curr_block 495, score 0; next_block 800: blocked, no ROM read; next_block 495: no pulse.
REQ-038 Tick at T, second tick at T+1 with next_block 497: second dropped, only curr_block 496 committed.
REQ-039 Reset asserted during EAT: next cycle curr_block 495, score 0, ready 0, INIT restarts from address 0.
REQ-040 Wall model open only at 495, 496: after INIT remaining 1; move to 496 -> score 10, level_clear 1; later ticks ignored, curr_block stays 496.

Source files
------------

// File: rtl/pac_man_pkg.sv
// pac_man_pkg
//   Shared maze geometry, scoring constants, block index type and the
//   mover state encoding used by pac_man_mover and pellet_map.
package pac_man_pkg;

  localparam int GRID_W        = 32;
  localparam int GRID_H        = 24;
  localparam int NUM_BLOCKS    = GRID_W * GRID_H;
  localparam int START_BLOCK   = 495;
  localparam int PELLET_POINTS = 10;
  localparam int BLOCK_BITS    = 10;

  typedef logic [BLOCK_BITS-1:0] block_t;

  typedef enum logic [2:0] {
    INIT,
    IDLE,
    CHECK,
    EAT,
    DONE
  } mover_state_t;

endpackage

// File: rtl/pellet_map.sv
// pellet_map
//   One bit per maze block: 1 = a pellet is still present.
//   Ports:
//     clk      - clock
//     wr_en    - write strobe
//     wr_addr  - block index to write
//     wr_data  - pellet bit to store
//     rd_addr  - block index to read
//     rd_data  - pellet bit of rd_addr, registered (1-cycle latency)
//   No reset: the mover rewrites every entry after each reset.
module pellet_map
  import pac_man_pkg::*;
#(
  parameter int DEPTH = NUM_BLOCKS
) (
  input  logic   clk,
  input  logic   wr_en,
  input  block_t wr_addr,
  input  logic   wr_data,
  input  block_t rd_addr,
  output logic   rd_data
);

  logic mem [DEPTH];

  // Write-before-read ordering at the same address is not needed by the mover.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
    rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/pac_man_mover.sv
// pac_man_mover
//   Commits Pac-Man moves requested by the direction stage, checking the
//   maze wall ROM, eating pellets and accumulating the score.
//   Ports:
//     clk, reset     - clock, synchronous active-high reset
//     move_tick      - single-cycle movement strobe
//     next_block     - requested destination block
//     wall_rd_addr   - wall ROM address (registered)
//     wall_rd_data   - wall bit, valid in the cycle after the address is issued
//     curr_block     - committed Pac-Man block
//     ready          - high only while idle
//     moved/blocked/pellet_eaten - one-cycle event pulses
//     score          - saturating score
//     level_clear    - sticky, all pellets eaten
module pac_man_mover
  import pac_man_pkg::*;
#(
  parameter int GRID_W        = pac_man_pkg::GRID_W,
  parameter int GRID_H        = pac_man_pkg::GRID_H,
  parameter int START_BLOCK   = pac_man_pkg::START_BLOCK,
  parameter int PELLET_POINTS = pac_man_pkg::PELLET_POINTS
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        move_tick,
  input  logic [9:0]  next_block,
  output logic [9:0]  wall_rd_addr,
  input  logic        wall_rd_data,
  output logic [9:0]  curr_block,
  output logic        ready,
  output logic        moved,
  output logic        blocked,
  output logic        pellet_eaten,
  output logic [15:0] score,
  output logic        level_clear
);

  localparam logic [10:0] BLOCK_COUNT = 11'(GRID_W * GRID_H);
  localparam logic [10:0] START_IDX   = 11'(START_BLOCK);

  mover_state_t state;
  logic [10:0]  sweep;
  logic         sweep_open;
  block_t       target;
  logic [9:0]   remaining;
  logic         pellet_bit;

  logic         map_wr_en;
  block_t       map_wr_addr;
  logic         map_wr_data;
  logic         init_write;
  logic [9:0]   remaining_init_next;
  logic [16:0]  score_sum;

  // The target register doubles as the pellet read address, so the read
  // issued while in CHECK returns the target's pellet bit in EAT.
  pellet_map #(
    .DEPTH(GRID_W * GRID_H)
  ) u_pellet_map (
    .clk    (clk),
    .wr_en  (map_wr_en),
    .wr_addr(map_wr_addr),
    .wr_data(map_wr_data),
    .rd_addr(target),
    .rd_data(pellet_bit)
  );

  // During INIT the write trails the sweep address by one cycle: sweep_open
  // holds the open/closed verdict captured for block sweep-1.
  always_comb begin
    init_write  = (state == INIT) && (sweep != 11'd0);
    map_wr_en   = 1'b0;
    map_wr_addr = target;
    map_wr_data = 1'b0;
    if (init_write) begin
      map_wr_en   = 1'b1;
      map_wr_addr = block_t'(sweep - 11'd1);
      map_wr_data = sweep_open;
    end else if ((state == EAT) && pellet_bit) begin
      map_wr_en   = 1'b1;
    end
    remaining_init_next = remaining + {9'd0, init_write & sweep_open};
    score_sum           = {1'b0, score} + 17'(PELLET_POINTS);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= INIT;
      sweep        <= '0;
      sweep_open   <= 1'b0;
      target       <= block_t'(START_BLOCK);
      curr_block   <= block_t'(START_BLOCK);
      remaining    <= '0;
      score        <= '0;
      level_clear  <= 1'b0;
      ready        <= 1'b0;
      moved        <= 1'b0;
      blocked      <= 1'b0;
      pellet_eaten <= 1'b0;
      wall_rd_addr <= '0;
    end else begin
      moved        <= 1'b0;
      blocked      <= 1'b0;
      pellet_eaten <= 1'b0;
      case (state)
        INIT: begin
          if (init_write) begin
            remaining <= remaining_init_next;
          end
          if (sweep < BLOCK_COUNT) begin
            sweep_open   <= ~wall_rd_data && (sweep != START_IDX);
            wall_rd_addr <= ((sweep + 11'd1) < BLOCK_COUNT) ? block_t'(sweep + 11'd1) : '0;
            sweep        <= sweep + 11'd1;
          end else if (remaining_init_next == 10'd0) begin
            level_clear <= 1'b1;
            state       <= DONE;
          end else begin
            ready <= 1'b1;
            state <= IDLE;
          end
        end
        IDLE: begin
          if (move_tick) begin
            if ({1'b0, next_block} >= BLOCK_COUNT) begin
              blocked <= 1'b1;
            end else if (next_block != curr_block) begin
              target       <= next_block;
              wall_rd_addr <= next_block;
              ready        <= 1'b0;
              state        <= CHECK;
            end
          end
        end
        CHECK: begin
          if (wall_rd_data) begin
            blocked <= 1'b1;
            ready   <= 1'b1;
            state   <= IDLE;
          end else begin
            curr_block <= target;
            moved      <= 1'b1;
            state      <= EAT;
          end
        end
        EAT: begin
          if (pellet_bit) begin
            score        <= score_sum[16] ? 16'hFFFF : score_sum[15:0];
            remaining    <= remaining - 10'd1;
            pellet_eaten <= 1'b1;
            if (remaining == 10'd1) begin
              level_clear <= 1'b1;
              state       <= DONE;
            end else begin
              ready <= 1'b1;
              state <= IDLE;
            end
          end else begin
            ready <= 1'b1;
            state <= IDLE;
          end
        end
        DONE: begin
          state <= DONE;
        end
        default: begin
          state <= INIT;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pac_man_mover.sv
// tb_pac_man_mover
//   Directed bench for pac_man_mover. The wall ROM is modelled as a lookup of
//   the registered wall_rd_addr, so data appears in the cycle after the mover
//   issues an address. Outputs are sampled 1 time unit after each rising edge.
module tb_pac_man_mover;

  logic        clk;
  logic        reset;
  logic        move_tick;
  logic [9:0]  next_block;
  logic [9:0]  wall_rd_addr;
  logic        wall_rd_data;
  logic [9:0]  curr_block;
  logic        ready;
  logic        moved;
  logic        blocked;
  logic        pellet_eaten;
  logic [15:0] score;
  logic        level_clear;

  logic wall_map [768];

  int n_compared;
  int n_mismatched;

  typedef struct {
    logic        tick;
    logic [9:0]  nb;
    logic        exp_moved;
    logic        exp_blocked;
    logic        exp_pellet;
    logic        exp_ready;
    logic [9:0]  exp_curr;
    logic [15:0] exp_score;
    logic [9:0]  exp_addr;
    string       name;
  } vec_t;

  vec_t vecs [16];

  pac_man_mover dut (
    .clk         (clk),
    .reset       (reset),
    .move_tick   (move_tick),
    .next_block  (next_block),
    .wall_rd_addr(wall_rd_addr),
    .wall_rd_data(wall_rd_data),
    .curr_block  (curr_block),
    .ready       (ready),
    .moved       (moved),
    .blocked     (blocked),
    .pellet_eaten(pellet_eaten),
    .score       (score),
    .level_clear (level_clear)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always_comb begin
    wall_rd_data = (wall_rd_addr < 10'd768) ? wall_map[wall_rd_addr] : 1'b1;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_stimulus(input logic tick, input logic [9:0] nb);
    move_tick  = tick;
    next_block = nb;
  endtask

  task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
    n_compared++;
    if (actual !== expected) begin
      n_mismatched++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  task automatic set_walls(input logic fill);
    for (int i = 0; i < 768; i++) begin
      wall_map[i] = fill;
    end
  endtask

  task automatic hold_reset();
    apply_stimulus(1'b0, 10'd0);
    reset = 1'b1;
    step();
    step();
  endtask

  // Counts rising edges until INIT ends (ready or level_clear), bounded.
  task automatic wait_init_end(input int start_count, output int cycles);
    cycles = start_count;
    while (!(ready || level_clear) && cycles < 2000) begin
      step();
      cycles++;
    end
  endtask

  task automatic do_move(input logic [9:0] nb);
    apply_stimulus(1'b1, nb);
    step();
    apply_stimulus(1'b0, nb);
    step();
    step();
  endtask

  initial begin
    int cycles;
    n_compared   = 0;
    n_mismatched = 0;
    reset        = 1'b1;
    apply_stimulus(1'b0, 10'd0);

    vecs[0]  = '{1'b1, 10'd496, 1'b0, 1'b0, 1'b0, 1'b0, 10'd495, 16'd0,  10'd496, "tick_496"};
    vecs[1]  = '{1'b0, 10'd496, 1'b1, 1'b0, 1'b0, 1'b0, 10'd496, 16'd0,  10'd496, "move_496"};
    vecs[2]  = '{1'b0, 10'd496, 1'b0, 1'b0, 1'b1, 1'b1, 10'd496, 16'd10, 10'd496, "eat_496"};
    vecs[3]  = '{1'b1, 10'd495, 1'b0, 1'b0, 1'b0, 1'b0, 10'd496, 16'd10, 10'd495, "tick_495"};
    vecs[4]  = '{1'b0, 10'd495, 1'b1, 1'b0, 1'b0, 1'b0, 10'd495, 16'd10, 10'd495, "move_495"};
    vecs[5]  = '{1'b0, 10'd495, 1'b0, 1'b0, 1'b0, 1'b1, 10'd495, 16'd10, 10'd495, "no_pellet_495"};
    vecs[6]  = '{1'b1, 10'd463, 1'b0, 1'b0, 1'b0, 1'b0, 10'd495, 16'd10, 10'd463, "tick_wall"};
    vecs[7]  = '{1'b0, 10'd463, 1'b0, 1'b1, 1'b0, 1'b1, 10'd495, 16'd10, 10'd463, "wall_blocked"};
    vecs[8]  = '{1'b0, 10'd463, 1'b0, 1'b0, 1'b0, 1'b1, 10'd495, 16'd10, 10'd463, "blocked_clear"};
    vecs[9]  = '{1'b1, 10'd800, 1'b0, 1'b1, 1'b0, 1'b1, 10'd495, 16'd10, 10'd463, "out_of_range"};
    vecs[10] = '{1'b1, 10'd495, 1'b0, 1'b0, 1'b0, 1'b1, 10'd495, 16'd10, 10'd463, "same_block"};
    vecs[11] = '{1'b0, 10'd495, 1'b0, 1'b0, 1'b0, 1'b1, 10'd495, 16'd10, 10'd463, "quiet"};
    vecs[12] = '{1'b1, 10'd496, 1'b0, 1'b0, 1'b0, 1'b0, 10'd495, 16'd10, 10'd496, "tick_a"};
    vecs[13] = '{1'b1, 10'd497, 1'b1, 1'b0, 1'b0, 1'b0, 10'd496, 16'd10, 10'd496, "tick_b_dropped"};
    vecs[14] = '{1'b0, 10'd497, 1'b0, 1'b0, 1'b0, 1'b1, 10'd496, 16'd10, 10'd496, "already_eaten"};
    vecs[15] = '{1'b0, 10'd497, 1'b0, 1'b0, 1'b0, 1'b1, 10'd496, 16'd10, 10'd496, "hold_496"};

    // Open maze with a single wall above the spawn block.
    set_walls(1'b0);
    wall_map[463] = 1'b1;
    hold_reset();
    check_output("rst_curr", 32'(curr_block), 32'd495);
    check_output("rst_score", 32'(score), 32'd0);
    check_output("rst_ready", 32'(ready), 32'd0);
    check_output("rst_addr", 32'(wall_rd_addr), 32'd0);
    check_output("rst_level", 32'(level_clear), 32'd0);

    reset = 1'b0;
    wait_init_end(0, cycles);
    check_output("init_cycles", 32'(cycles), 32'd769);
    check_output("init_ready", 32'(ready), 32'd1);
    check_output("init_curr", 32'(curr_block), 32'd495);
    check_output("init_score", 32'(score), 32'd0);
    check_output("init_level", 32'(level_clear), 32'd0);

    for (int i = 0; i < 16; i++) begin
      apply_stimulus(vecs[i].tick, vecs[i].nb);
      step();
      check_output({vecs[i].name, "_moved"},   32'(moved),        32'(vecs[i].exp_moved));
      check_output({vecs[i].name, "_blocked"}, 32'(blocked),      32'(vecs[i].exp_blocked));
      check_output({vecs[i].name, "_pellet"},  32'(pellet_eaten), 32'(vecs[i].exp_pellet));
      check_output({vecs[i].name, "_ready"},   32'(ready),        32'(vecs[i].exp_ready));
      check_output({vecs[i].name, "_curr"},    32'(curr_block),   32'(vecs[i].exp_curr));
      check_output({vecs[i].name, "_score"},   32'(score),        32'(vecs[i].exp_score));
      check_output({vecs[i].name, "_addr"},    32'(wall_rd_addr), 32'(vecs[i].exp_addr));
    end
    apply_stimulus(1'b0, 10'd0);

    // Reset landing in EAT while a pellet is about to be consumed.
    apply_stimulus(1'b1, 10'd497);
    step();
    apply_stimulus(1'b0, 10'd497);
    step();
    check_output("pre_rst_moved", 32'(moved), 32'd1);
    check_output("pre_rst_curr", 32'(curr_block), 32'd497);
    reset = 1'b1;
    step();
    check_output("mid_rst_curr", 32'(curr_block), 32'd495);
    check_output("mid_rst_score", 32'(score), 32'd0);
    check_output("mid_rst_ready", 32'(ready), 32'd0);
    check_output("mid_rst_pellet", 32'(pellet_eaten), 32'd0);
    check_output("mid_rst_addr", 32'(wall_rd_addr), 32'd0);
    reset = 1'b0;
    step();
    check_output("reinit_addr1", 32'(wall_rd_addr), 32'd1);
    step();
    check_output("reinit_addr2", 32'(wall_rd_addr), 32'd2);
    wait_init_end(2, cycles);
    check_output("reinit_cycles", 32'(cycles), 32'd769);
    do_move(10'd496);
    check_output("refill_pellet", 32'(pellet_eaten), 32'd1);
    check_output("refill_score", 32'(score), 32'd10);

    // Only 495 and 496 open: a single pellet remains after INIT.
    set_walls(1'b1);
    wall_map[495] = 1'b0;
    wall_map[496] = 1'b0;
    hold_reset();
    reset = 1'b0;
    wait_init_end(0, cycles);
    check_output("one_cycles", 32'(cycles), 32'd769);
    check_output("one_ready", 32'(ready), 32'd1);
    check_output("one_level_pre", 32'(level_clear), 32'd0);
    do_move(10'd496);
    check_output("one_pellet", 32'(pellet_eaten), 32'd1);
    check_output("one_score", 32'(score), 32'd10);
    check_output("one_level", 32'(level_clear), 32'd1);
    check_output("one_ready_done", 32'(ready), 32'd0);
    do_move(10'd495);
    check_output("done_curr", 32'(curr_block), 32'd496);
    check_output("done_moved", 32'(moved), 32'd0);
    check_output("done_level", 32'(level_clear), 32'd1);
    check_output("done_score", 32'(score), 32'd10);

    // Fully walled maze: nothing to eat, level is clear at INIT end.
    set_walls(1'b1);
    hold_reset();
    reset = 1'b0;
    wait_init_end(0, cycles);
    check_output("empty_cycles", 32'(cycles), 32'd769);
    check_output("empty_level", 32'(level_clear), 32'd1);
    check_output("empty_ready", 32'(ready), 32'd0);
    do_move(10'd494);
    check_output("empty_curr", 32'(curr_block), 32'd495);
    check_output("empty_blocked", 32'(blocked), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
